adder_checker_16bit: RTL and testbench

ADDER_CHECKER_16BIT -- requirements
Module: adder_checker_16bit

---
 rtl/adder_checker_16bit.sv | 121 ++++++++++++
 tb/tb_adder_checker_16bit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/adder_checker_16bit.sv
// adder_checker_16bit: run-controlled checker for an external adder with saturating pass/fail counters.
// Optional first-failure capture is enabled by defining CHK_FIRST_FAIL_CAPTURE_EN.
module adder_checker_16bit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    output logic             mismatch,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             done,
    output logic             ff_valid,
    output logic [WIDTH-1:0] ff_a,
    output logic [WIDTH-1:0] ff_b,
    output logic             ff_cin,
    output logic [WIDTH:0]   ff_sum
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic             accept;
    logic             run_start;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_cin;
    logic [WIDTH:0]   s1_obs;
    logic [WIDTH:0]   expected;
    logic             s2_fail;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb
        state_nx = (state == IDLE && start) ? RUN :
                   (state == RUN && stop)   ? DRAIN :
                   (state == DRAIN)         ? DONE :
                   (state == DONE && clear) ? IDLE : state;

    always_comb begin
        in_ready = state == RUN;
        done     = state == DONE;
    end

    assign accept    = in_valid & in_ready;
    assign run_start = state == IDLE && start;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_cin   <= 1'b0;
            s1_obs   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_a   <= a;
                s1_b   <= b;
                s1_cin <= cin;
                s1_obs <= {cout, sum};
            end
        end

    assign expected = {1'b0, s1_a} + {1'b0, s1_b} + {{WIDTH{1'b0}}, s1_cin};
    assign s2_fail  = s1_obs != expected;

    // Counters saturate at all-ones; a new run is the only thing that zeroes them.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pass_count <= '0;
            fail_count <= '0;
            mismatch   <= 1'b0;
        end else begin
            mismatch <= s1_valid & s2_fail;
            if (run_start) begin
                pass_count <= '0;
                fail_count <= '0;
            end else if (s1_valid && s2_fail)
                fail_count <= (&fail_count) ? fail_count : fail_count + CNT_W'(1);
            else if (s1_valid)
                pass_count <= (&pass_count) ? pass_count : pass_count + CNT_W'(1);
        end

`ifdef CHK_FIRST_FAIL_CAPTURE_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ff_valid <= 1'b0;
            ff_a     <= '0;
            ff_b     <= '0;
            ff_cin   <= 1'b0;
            ff_sum   <= '0;
        end else if (run_start)
            ff_valid <= 1'b0;
        else if (s1_valid && s2_fail && !ff_valid) begin
            ff_valid <= 1'b1;
            ff_a     <= s1_a;
            ff_b     <= s1_b;
            ff_cin   <= s1_cin;
            ff_sum   <= s1_obs;
        end
`else
    assign ff_valid = 1'b0;
    assign ff_a     = '0;
    assign ff_b     = '0;
    assign ff_cin   = 1'b0;
    assign ff_sum   = '0;
`endif

endmodule

// File: tb/tb_adder_checker_16bit.sv
// tb_adder_checker_16bit: directed + random check of adder_checker_16bit against a cycle-level reference model.
// A second instance with CNT_W=2 exercises counter saturation on the same stimulus.
module tb_adder_checker_16bit;
    localparam int W = 16;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic in_valid = 1'b0, cin = 1'b0, cout = 1'b0;
    logic [W-1:0] a = '0, b = '0, sum = '0;
    logic in_ready, mismatch, done, ff_valid, ff_cin;
    logic [15:0] pass_count, fail_count;
    logic [W-1:0] ff_a, ff_b;
    logic [W:0] ff_sum;
    logic s_in_ready, s_mismatch, s_done, s_ff_valid, s_ff_cin;
    logic [1:0] s_pass, s_fail;
    logic [W-1:0] s_ff_a, s_ff_b;
    logic [W:0] s_ff_sum;

    int m_state, m_pass, m_fail, n_checks = 0, n_fail = 0;
    logic m_mis, m_ffv, m_ffc, p_v, p_cin, p_cout;
    logic [W-1:0] m_ffa, m_ffb, p_a, p_b, p_sum;
    logic [W:0] m_ffs;

    adder_checker_16bit #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
        .mismatch(mismatch), .pass_count(pass_count), .fail_count(fail_count), .done(done),
        .ff_valid(ff_valid), .ff_a(ff_a), .ff_b(ff_b), .ff_cin(ff_cin), .ff_sum(ff_sum));

    adder_checker_16bit #(.WIDTH(W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
        .in_valid(in_valid), .in_ready(s_in_ready), .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
        .mismatch(s_mismatch), .pass_count(s_pass), .fail_count(s_fail), .done(s_done),
        .ff_valid(s_ff_valid), .ff_a(s_ff_a), .ff_b(s_ff_b), .ff_cin(s_ff_cin), .ff_sum(s_ff_sum));

    always #5 clk = ~clk;

    function automatic int sat_at(input int v, input int w);
        return v > (1 << w) - 1 ? (1 << w) - 1 : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("in_ready", 32'(in_ready), 32'(m_state == 1));
        chk("done", 32'(done), 32'(m_state == 3));
        chk("mismatch", 32'(mismatch), 32'(m_mis));
        chk("pass_count", 32'(pass_count), 32'(sat_at(m_pass, 16)));
        chk("fail_count", 32'(fail_count), 32'(sat_at(m_fail, 16)));
        chk("sat_pass", 32'(s_pass), 32'(sat_at(m_pass, 2)));
        chk("sat_fail", 32'(s_fail), 32'(sat_at(m_fail, 2)));
        chk("sat_mismatch", 32'(s_mismatch), 32'(m_mis));
        chk("ff_valid", 32'(ff_valid), 32'(m_ffv));
        chk("ff_a", 32'(ff_a), 32'(m_ffa));
        chk("ff_b", 32'(ff_b), 32'(m_ffb));
        chk("ff_cin", 32'(ff_cin), 32'(m_ffc));
        chk("ff_sum", 32'(ff_sum), 32'(m_ffs));
    endtask

    task automatic model_reset();
        m_state = 0; m_pass = 0; m_fail = 0; m_mis = 0; p_v = 0;
        m_ffv = 0; m_ffa = '0; m_ffb = '0; m_ffc = 0; m_ffs = '0;
    endtask

    // One clock cycle: drive controls and an optional vector, advance the model, then check.
    task automatic cyc(input logic st, input logic sp, input logic cl, input logic v,
                       input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ici,
                       input logic [W-1:0] isum, input logic ico);
        logic acc;
        int e;
        start = st; stop = sp; clear = cl; in_valid = v;
        a = ia; b = ib; cin = ici; sum = isum; cout = ico;
        acc = v && m_state == 1;
        @(posedge clk);
        m_mis = 0;
        if (p_v) begin
            e = int'(p_a) + int'(p_b) + int'(p_cin);
            if (e == int'({p_cout, p_sum})) m_pass++;
            else begin
                m_fail++;
                m_mis = 1;
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
                if (!m_ffv) begin
                    m_ffv = 1; m_ffa = p_a; m_ffb = p_b; m_ffc = p_cin; m_ffs = {p_cout, p_sum};
                end
`endif
            end
        end
        case (m_state)
            0: if (st) begin m_state = 1; m_pass = 0; m_fail = 0; m_ffv = 0; end
            1: if (sp) m_state = 2;
            2: m_state = 3;
            default: if (cl) m_state = 0;
        endcase
        p_v = acc; p_a = ia; p_b = ib; p_cin = ici; p_sum = isum; p_cout = ico;
        #1;
        start = 0; stop = 0; clear = 0; in_valid = 0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, '0, '0, 0, '0, 0);
    endtask

    task automatic vec(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ici,
                       input logic [W-1:0] isum, input logic ico);
        cyc(0, 0, 0, 1, ia, ib, ici, isum, ico);
    endtask

    task automatic async_reset();
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic rc, rv;
        logic [W:0] obs;
        model_reset();
        #3;
        check_all();
        @(negedge clk);
        rst_n = 1;
        idle(1);
        // Illegal controls and vectors outside RUN are ignored.
        cyc(0, 1, 1, 1, 16'd1, 16'd1, 0, 16'd5, 0);
        idle(1);
        cyc(1, 0, 0, 0, '0, '0, 0, '0, 0);
        vec(16'hFFFF, 16'hFFFF, 1, 16'hFFFF, 1);
        idle(2);
        vec(16'd2, 16'd3, 0, 16'd0, 0);
        idle(2);
        cyc(1, 0, 1, 0, '0, '0, 0, '0, 0);
        for (int i = 0; i < 5; i++) vec(16'(i), 16'd7, 0, 16'hAAAA, 0);
        idle(2);
        cyc(0, 1, 0, 0, '0, '0, 0, '0, 0);
        idle(2);
        cyc(0, 0, 1, 0, '0, '0, 0, '0, 0);
        cyc(1, 0, 0, 0, '0, '0, 0, '0, 0);
        vec(16'd15, 16'd15, 1, 16'd0, 0);
        vec(16'd1, 16'd1, 0, 16'd0, 0);
        idle(2);
        for (int i = 0; i < 200; i++) begin
            rv = $urandom_range(0, 3) != 0;
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            obs = ($urandom_range(0, 9) < 6) ? 17'(int'(ra) + int'(rb) + int'(rc)) : 17'($urandom);
            cyc(0, 0, 0, rv, ra, rb, rc, obs[W-1:0], obs[W]);
        end
        idle(1);
        // Vector accepted on the same edge as stop is still counted before DONE is observed.
        cyc(0, 0, 1, 0, '0, '0, 0, '0, 0);
        cyc(0, 1, 0, 1, 16'd9, 16'd9, 0, 16'd18, 0);
        idle(3);
        cyc(1, 1, 0, 1, 16'd1, 16'd1, 0, 16'd2, 0);
        cyc(0, 0, 1, 0, '0, '0, 0, '0, 0);
        idle(2);
        cyc(1, 0, 0, 0, '0, '0, 0, '0, 0);
        vec(16'd4, 16'd4, 0, 16'd8, 0);
        vec(16'd4, 16'd4, 0, 16'd0, 0);
        async_reset();
        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
